// File: rtl/pwm_out_gen_if.sv
// Control/status bundle for pwm_out_gen: load/enable requests in, PWM waveform and active settings out.
interface pwm_out_gen_if #(
  parameter int unsigned CNT_W = 32
);
  logic             pwm_enable;
  logic             pwm_load;
  logic [CNT_W-1:0] pwm_period_in;
  logic [CNT_W-1:0] pwm_ontime_in;
  logic             pwm_pwm_out;
  logic [CNT_W-1:0] pwm_period_active;
  logic [CNT_W-1:0] pwm_ontime_active;
  logic             pwm_cycle_start;
  logic             pwm_busy;

  modport master (
    output pwm_enable, pwm_load, pwm_period_in, pwm_ontime_in,
    input  pwm_pwm_out, pwm_period_active, pwm_ontime_active, pwm_cycle_start, pwm_busy
  );

  modport slave (
    input  pwm_enable, pwm_load, pwm_period_in, pwm_ontime_in,
    output pwm_pwm_out, pwm_period_active, pwm_ontime_active, pwm_cycle_start, pwm_busy
  );
endinterface

// File: rtl/pwm_out_gen.sv
// PWM generator with shadowed period/on-time settings that take effect only on period boundaries.
// Every output is a flop whose value is computed for the slot the counter is entering.
module pwm_out_gen #(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned MIN_PERIOD = 2
) (
  input logic         xclk,
  input logic         reset,
  pwm_out_gen_if.slave bus
);

  localparam logic [CNT_W-1:0] MIN_P = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] shadow_period;
  logic [CNT_W-1:0] shadow_ontime;
  logic [CNT_W-1:0] period_act;
  logic [CNT_W-1:0] ontime_act;
  logic             pending;
  logic             pwm_out;
  logic             cycle_start;
  logic             busy;

  logic             boundary;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] next_period;
  logic [CNT_W-1:0] next_ontime;

  // RUN only holds periods >= MIN_PERIOD, so period_act-1 and cnt+1 never wrap there.
  assign boundary    = (cnt == (period_act - ONE));
  assign cnt_inc     = cnt + ONE;
  assign next_period = pending ? shadow_period : period_act;
  assign next_ontime = pending ? shadow_ontime : ontime_act;

  always_ff @(posedge xclk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      shadow_period <= '0;
      shadow_ontime <= '0;
      period_act    <= '0;
      ontime_act    <= '0;
      pending       <= 1'b0;
      pwm_out       <= 1'b0;
      cycle_start   <= 1'b0;
      busy          <= 1'b0;
    end else begin
      if (bus.pwm_load) begin
        shadow_period <= bus.pwm_period_in;
        shadow_ontime <= bus.pwm_ontime_in;
        pending       <= 1'b1;
      end

      case (state)
        IDLE: begin
          cnt         <= '0;
          pwm_out     <= 1'b0;
          cycle_start <= 1'b0;
          busy        <= 1'b0;
          // A pending transfer takes this cycle; the start decision then sees the new values.
          if (pending) begin
            period_act <= shadow_period;
            ontime_act <= shadow_ontime;
            if (!bus.pwm_load) pending <= 1'b0;
          end else if (bus.pwm_enable && (period_act >= MIN_P)) begin
            state       <= RUN;
            pwm_out     <= (ontime_act != '0);
            cycle_start <= 1'b1;
            busy        <= 1'b1;
          end
        end

        RUN: begin
          if (boundary) begin
            // Transfer uses the pre-load shadow; a coincident load stays pending.
            if (pending) begin
              period_act <= shadow_period;
              ontime_act <= shadow_ontime;
              if (!bus.pwm_load) pending <= 1'b0;
            end
            cnt <= '0;
            if (!bus.pwm_enable || (next_period < MIN_P)) begin
              state       <= IDLE;
              pwm_out     <= 1'b0;
              cycle_start <= 1'b0;
              busy        <= 1'b0;
            end else begin
              pwm_out     <= (next_ontime != '0);
              cycle_start <= 1'b1;
            end
          end else begin
            cnt         <= cnt_inc;
            pwm_out     <= (cnt_inc < ontime_act);
            cycle_start <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.pwm_pwm_out       = pwm_out;
  assign bus.pwm_period_active = period_act;
  assign bus.pwm_ontime_active = ontime_act;
  assign bus.pwm_cycle_start   = cycle_start;
  assign bus.pwm_busy          = busy;

endmodule

// File: tb/tb_pwm_out_gen.sv
// Directed bench for pwm_out_gen: waveform shape, shadow transfer timing, stop, short period and reset.
`timescale 1ns/1ps
module tb_pwm_out_gen;

  localparam int unsigned CNT_W = 32;

  logic xclk;
  logic reset;
  int   total;
  int   bad;

  pwm_out_gen_if #(.CNT_W(CNT_W)) bus ();

  pwm_out_gen #(.CNT_W(CNT_W), .MIN_PERIOD(2)) dut (
    .xclk  (xclk),
    .reset (reset),
    .bus   (bus)
  );

  initial xclk = 1'b0;
  always #6.667 xclk = ~xclk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one edge and settle before sampling.
  task automatic tick();
    @(posedge xclk);
    #1;
  endtask

  task automatic load_vals(input int p, input int o);
    bus.pwm_load      = 1'b1;
    bus.pwm_period_in = 32'(p);
    bus.pwm_ontime_in = 32'(o);
    tick();
    bus.pwm_load      = 1'b0;
  endtask

  task automatic wait_cs(input int budget);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.pwm_cycle_start && n < budget);
    check_eq("wait_cycle_start", 32'(bus.pwm_cycle_start), 32'd1);
  endtask

  // Starting at slot 0, check n consecutive slots of a per/on waveform.
  task automatic run_check(input int n, input int per, input int on);
    for (int k = 0; k < n; k++) begin
      check_eq("pwm_out",     32'(bus.pwm_pwm_out),     32'((k % per) < on));
      check_eq("cycle_start", 32'(bus.pwm_cycle_start), 32'((k % per) == 0));
      check_eq("busy",        32'(bus.pwm_busy),        32'd1);
      tick();
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_out"},  32'(bus.pwm_pwm_out),     32'd0);
    check_eq({tag, "_busy"}, 32'(bus.pwm_busy),        32'd0);
    check_eq({tag, "_cs"},   32'(bus.pwm_cycle_start), 32'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.pwm_enable    = 1'b0;
    bus.pwm_load      = 1'b0;
    bus.pwm_period_in = '0;
    bus.pwm_ontime_in = '0;
    tick();
    tick();
    reset = 1'b0;
    check_idle("rst");
    check_eq("rst_period", bus.pwm_period_active, 32'd0);
    check_eq("rst_ontime", bus.pwm_ontime_active, 32'd0);

    // 10/3 steady waveform
    bus.pwm_enable = 1'b1;
    load_vals(10, 3);
    wait_cs(16);
    check_eq("a_period", bus.pwm_period_active, 32'd10);
    check_eq("a_ontime", bus.pwm_ontime_active, 32'd3);
    run_check(20, 10, 3);

    // Mid-period load of 20/15 at slot 4
    repeat (4) tick();
    load_vals(20, 15);
    for (int k = 5; k < 10; k++) begin
      check_eq("b_old_out",    32'(bus.pwm_pwm_out), 32'(k < 3));
      check_eq("b_old_period", bus.pwm_period_active, 32'd10);
      tick();
    end
    check_eq("b_new_period", bus.pwm_period_active, 32'd20);
    check_eq("b_new_ontime", bus.pwm_ontime_active, 32'd15);
    run_check(20, 20, 15);

    // Degenerate on-times
    load_vals(8, 0);
    wait_cs(64);
    check_eq("c0_ontime", bus.pwm_ontime_active, 32'd0);
    run_check(16, 8, 0);
    load_vals(8, 8);
    wait_cs(64);
    run_check(16, 8, 8);
    load_vals(8, 12);
    wait_cs(64);
    check_eq("c2_ontime", bus.pwm_ontime_active, 32'd12);
    run_check(16, 8, 12);

    // Enable dropped at slot 2 of 10/5
    load_vals(10, 5);
    wait_cs(64);
    tick();
    tick();
    bus.pwm_enable = 1'b0;
    for (int k = 2; k < 10; k++) begin
      check_eq("d_out",  32'(bus.pwm_pwm_out), 32'(k < 5));
      check_eq("d_busy", 32'(bus.pwm_busy),    32'd1);
      tick();
    end
    check_idle("d_stop");
    tick();
    check_idle("d_stay");

    // Short period forces IDLE; coincident load stays pending
    bus.pwm_enable = 1'b1;
    tick();
    check_eq("e_start_cs", 32'(bus.pwm_cycle_start), 32'd1);
    load_vals(1, 1);
    repeat (8) tick();
    load_vals(5, 2);
    check_idle("e_short");
    check_eq("e_period1", bus.pwm_period_active, 32'd1);
    check_eq("e_ontime1", bus.pwm_ontime_active, 32'd1);
    tick();
    check_eq("e_period5", bus.pwm_period_active, 32'd5);
    check_eq("e_ontime2", bus.pwm_ontime_active, 32'd2);
    check_eq("e_busy_xfer", 32'(bus.pwm_busy), 32'd0);
    tick();
    run_check(10, 5, 2);

    // Reset mid-period
    load_vals(10, 3);
    wait_cs(64);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle("f_rst");
    check_eq("f_period", bus.pwm_period_active, 32'd0);
    check_eq("f_ontime", bus.pwm_ontime_active, 32'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check_idle("f_hold");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
